apb_master_bridge: RTL and testbench

- Upstream APB requester that feeds the team's 256x32 APB memory slave.
- Accepts simple valid/ready read/write requests from a local agent (CPU model, DMA, test sequencer) and buffers them in a small request FIFO.
- Drives fixed two-phase APB transfers (SETUP, then ACCESS); the slave has no PREADY, so every transfer is exactly 2 cycles.
- Returns a one-cycle response pulse carrying read data.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_master_bridge_if.sv | 33 +++
 rtl/apb_req_fifo.sv | 54 +++++
 rtl/apb_master_bridge.sv | 131 +++++++++++++
 tb/tb_apb_master_bridge.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB types for the request bridge: bus widths, queued request record, FSM states.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 16;
  localparam int unsigned APB_DATA_W = 32;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [31:0] data;
  } apb_req_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Local request/response handshake plus APB bus of the bridge; master = bridge side.
interface apb_master_bridge_if;
  import apb_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [APB_ADDR_W-1:0] req_addr;
  logic [APB_DATA_W-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_write;
  logic [APB_DATA_W-1:0] rsp_rdata;
  logic                  busy;
  logic [APB_ADDR_W-1:0] PAddr;
  logic [APB_DATA_W-1:0] PWData;
  logic                  PWrite;
  logic                  PSel;
  logic                  PEnable;
  logic [APB_DATA_W-1:0] PRData;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRData,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, busy,
           PAddr, PWData, PWrite, PSel, PEnable
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRData,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, busy,
           PAddr, PWData, PWrite, PSel, PEnable
  );

endinterface

// File: rtl/apb_req_fifo.sv
// Request FIFO; pointers carry one extra wrap bit to tell full from empty.
module apb_req_fifo
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     Rst,
  input  logic     push_i,
  input  logic     pop_i,
  input  apb_req_t wdata_i,
  output apb_req_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  apb_req_t    mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Push is gated on the registered full flag only, so a same-cycle pop never frees a slot.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Queues local requests and replays them as fixed two-cycle APB transfers with a response pulse.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                Rst,
  apb_master_bridge_if.master bus
);

  apb_state_e            state_q, state_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  apb_req_t push_req;
  apb_req_t head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     pop;

  assign push_req = '{write: bus.req_write, addr: bus.req_addr, data: bus.req_wdata};

  apb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .Rst     (Rst),
    .push_i  (bus.req_valid),
    .pop_i   (pop),
    .wdata_i (push_req),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          paddr_d   = head.addr;
          pwdata_d  = head.data;
          pwrite_d  = head.write;
          psel_d    = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_write_d = pwrite_q;
        rsp_rdata_d = pwrite_q ? '0 : bus.PRData;
        penable_d   = 1'b0;
        // Chain straight into the next SETUP so PSel never drops between queued transfers.
        if (!fifo_empty) begin
          pop      = 1'b1;
          paddr_d  = head.addr;
          pwdata_d = head.data;
          pwrite_d = head.write;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end else begin
          psel_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = !fifo_full;
  assign bus.busy      = (state_q != IDLE) || !fifo_empty;
  assign bus.PAddr     = paddr_q;
  assign bus.PWData    = pwdata_q;
  assign bus.PWrite    = pwrite_q;
  assign bus.PSel      = psel_q;
  assign bus.PEnable   = penable_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a 256x32 APB memory slave model.
module tb_apb_master_bridge;

  logic clk;
  logic Rst;
  logic mem_clr;
  int   checks;
  int   errors;
  int   cyc;

  apb_master_bridge_if bus_if ();

  apb_master_bridge #(.DEPTH(4)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory slave: write commits at the edge ending ACCESS; read data is combinational.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (bus_if.PSel && bus_if.PEnable && bus_if.PWrite) begin
      mem[bus_if.PAddr[7:0]] <= bus_if.PWData;
    end
  end
  assign bus_if.PRData = (bus_if.PSel && !bus_if.PWrite) ? mem[bus_if.PAddr[7:0]] : 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rsp_d [64];
  logic        rsp_w [64];
  int          rsp_c [64];
  int          rsp_n;
  always @(negedge clk) begin
    if (bus_if.rsp_valid === 1'b1 && rsp_n < 64) begin
      rsp_d[rsp_n] <= bus_if.rsp_rdata;
      rsp_w[rsp_n] <= bus_if.rsp_write;
      rsp_c[rsp_n] <= cyc;
      rsp_n        <= rsp_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [15:0] a, input logic [31:0] d);
    bus_if.req_write = wr;
    bus_if.req_addr  = a;
    bus_if.req_wdata = d;
  endtask

  task automatic push(input logic wr, input logic [15:0] a, input logic [31:0] d);
    int n;
    n = 0;
    drive(wr, a, d);
    bus_if.req_valid = 1'b1;
    while (!bus_if.req_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("push_timeout", 32'd1, 32'd0);
    tick();
    bus_if.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n;
    n = 0;
    while (rsp_n < target && n < budget) begin
      tick();
      n++;
    end
    if (rsp_n < target) check("rsp_timeout", 32'(rsp_n), 32'(target));
  endtask

  // One isolated transfer from an idle bridge, checked cycle by cycle.
  task automatic xfer_check(input string tag, input logic wr, input logic [15:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rd);
    drive(wr, a, d);
    bus_if.req_valid = 1'b1;
    tick();
    bus_if.req_valid = 1'b0;
    check({tag, "_e0_psel"}, 32'(bus_if.PSel), 32'd0);
    check({tag, "_e0_busy"}, 32'(bus_if.busy), 32'd1);
    tick();
    check({tag, "_setup_psel"}, 32'(bus_if.PSel), 32'd1);
    check({tag, "_setup_pen"}, 32'(bus_if.PEnable), 32'd0);
    check({tag, "_setup_addr"}, 32'(bus_if.PAddr), 32'(a));
    check({tag, "_setup_wr"}, 32'(bus_if.PWrite), 32'(wr));
    check({tag, "_setup_wdata"}, bus_if.PWData, d);
    check({tag, "_setup_rsp"}, 32'(bus_if.rsp_valid), 32'd0);
    tick();
    check({tag, "_access_psel"}, 32'(bus_if.PSel), 32'd1);
    check({tag, "_access_pen"}, 32'(bus_if.PEnable), 32'd1);
    check({tag, "_access_rsp"}, 32'(bus_if.rsp_valid), 32'd0);
    tick();
    check({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd1);
    check({tag, "_rsp_write"}, 32'(bus_if.rsp_write), 32'(wr));
    check({tag, "_rsp_rdata"}, bus_if.rsp_rdata, wr ? 32'h0 : exp_rd);
    check({tag, "_rsp_psel"}, 32'(bus_if.PSel), 32'd0);
    check({tag, "_rsp_pen"}, 32'(bus_if.PEnable), 32'd0);
    tick();
    check({tag, "_pulse_end"}, 32'(bus_if.rsp_valid), 32'd0);
    check({tag, "_drained"}, 32'(bus_if.busy), 32'd0);
  endtask

  initial begin
    int base;
    int accepted;
    int guard;
    logic prev_ready;
    logic seen_full;

    checks = 0;
    errors = 0;
    cyc    = 0;
    rsp_n  = 0;
    Rst     = 1'b0;
    mem_clr = 1'b1;
    bus_if.req_valid = 1'b0;
    drive(1'b0, 16'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    check("rst_psel", 32'(bus_if.PSel), 32'd0);
    check("rst_pen", 32'(bus_if.PEnable), 32'd0);
    check("rst_paddr", 32'(bus_if.PAddr), 32'd0);
    check("rst_pwdata", bus_if.PWData, 32'd0);
    check("rst_rsp_rdata", bus_if.rsp_rdata, 32'd0);
    Rst = 1'b1;
    tick();
    check("rst_ready", 32'(bus_if.req_ready), 32'd1);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);

    xfer_check("rd_after_rst", 1'b0, 16'h00FF, 32'h0, 32'h0);
    xfer_check("wr10", 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0);
    xfer_check("rd10", 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF);

    // Back-to-back: 4 writes then 4 reads of the same words
    base = rsp_n;
    for (int i = 0; i < 4; i++) push(1'b1, 16'(i), 32'h100 + 32'(i));
    for (int i = 0; i < 4; i++) push(1'b0, 16'(i), 32'hAAAA0000 + 32'(i));
    wait_rsp(base + 8, 60);
    check("b2b_count", 32'(rsp_n - base), 32'd8);
    for (int i = 0; i < 4; i++) begin
      check("b2b_wr_flag", 32'(rsp_w[base + i]), 32'd1);
      check("b2b_wr_rdata", rsp_d[base + i], 32'h0);
      check("b2b_rd_flag", 32'(rsp_w[base + 4 + i]), 32'd0);
      check("b2b_rd_rdata", rsp_d[base + 4 + i], 32'h100 + 32'(i));
    end
    for (int i = 1; i < 8; i++)
      check("b2b_spacing", 32'(rsp_c[base + i] - rsp_c[base + i - 1]), 32'd2);

    // Idle drain: outputs hold the last transfer
    tick();
    check("drain_busy", 32'(bus_if.busy), 32'd0);
    check("drain_psel", 32'(bus_if.PSel), 32'd0);
    check("drain_paddr", 32'(bus_if.PAddr), 32'h3);
    check("drain_pwdata", bus_if.PWData, 32'hAAAA0003);
    check("drain_pwrite", 32'(bus_if.PWrite), 32'd0);
    check("drain_extra_rsp", 32'(rsp_n - base), 32'd8);

    // FIFO full under continuous req_valid
    base      = rsp_n;
    accepted  = 0;
    guard     = 0;
    seen_full = 1'b0;
    bus_if.req_valid = 1'b1;
    while (accepted < 12 && guard < 100) begin
      drive(1'b1, 16'h40 + 16'(accepted), 32'hC0DE0000 + 32'(accepted));
      prev_ready = bus_if.req_ready;
      tick();
      guard++;
      if (prev_ready) begin
        accepted++;
      end else begin
        seen_full = 1'b1;
        if (bus_if.PSel && !bus_if.PEnable)
          check("full_ready_after_pop", 32'(bus_if.req_ready), 32'd1);
        else
          check("full_ready_held", 32'(bus_if.req_ready), 32'd0);
      end
    end
    bus_if.req_valid = 1'b0;
    check("full_accepted", 32'(accepted), 32'd12);
    check("full_seen", 32'(seen_full), 32'd1);
    wait_rsp(base + 12, 60);
    repeat (4) tick();
    check("full_rsp_count", 32'(rsp_n - base), 32'd12);
    xfer_check("full_rd_first", 1'b0, 16'h0040, 32'h0, 32'hC0DE0000);
    xfer_check("full_rd_last", 1'b0, 16'h004B, 32'h0, 32'hC0DE000B);

    // Reset during ACCESS of a write with two more queued
    push(1'b1, 16'h0020, 32'h12345678);
    push(1'b1, 16'h0021, 32'h11111111);
    push(1'b1, 16'h0022, 32'h22222222);
    guard = 0;
    while (!(bus_if.PSel && bus_if.PEnable && bus_if.PAddr == 16'h0020) && guard < 20) begin
      tick();
      guard++;
    end
    check("abort_reached_access", 32'(bus_if.PSel && bus_if.PEnable), 32'd1);
    base = rsp_n;
    Rst = 1'b0;
    #1;
    check("abort_psel", 32'(bus_if.PSel), 32'd0);
    check("abort_pen", 32'(bus_if.PEnable), 32'd0);
    check("abort_busy", 32'(bus_if.busy), 32'd0);
    tick();
    tick();
    #2;
    Rst = 1'b1;
    tick();
    tick();
    check("abort_no_rsp", 32'(rsp_n - base), 32'd0);
    check("abort_busy_after", 32'(bus_if.busy), 32'd0);
    check("abort_ready_after", 32'(bus_if.req_ready), 32'd1);
    check("abort_psel_after", 32'(bus_if.PSel), 32'd0);
    xfer_check("abort_rd20", 1'b0, 16'h0020, 32'h0, 32'h0);
    xfer_check("abort_rd21", 1'b0, 16'h0021, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
